// File: rtl/common_types_pkg.sv
// -----------------------------------------------------------------------------
// common_types_pkg
// Shared types for the memory stage: the data word type, RV32I load/store
// access sizes (funct3 encoding), the load/store unit FSM states and the
// fault classes reported on completion.
// -----------------------------------------------------------------------------
package common_types_pkg;

    typedef logic [31:0] word_t;

    // funct3 encoding of load/store size and signedness.
    typedef enum logic [2:0] {
        LS_B  = 3'b000,
        LS_H  = 3'b001,
        LS_W  = 3'b010,
        LS_BU = 3'b100,
        LS_HU = 3'b101
    } mem_size_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUS  = 2'b01,
        DONE = 2'b10
    } lsu_state_t;

    typedef enum logic [1:0] {
        FLT_NONE     = 2'b00,
        FLT_MISALIGN = 2'b01,
        FLT_TIMEOUT  = 2'b10,
        FLT_ILLEGAL  = 2'b11
    } lsu_fault_t;

endpackage

// File: rtl/lsu_align.sv
// -----------------------------------------------------------------------------
// lsu_align
// Purely combinational byte-lane helper for the load/store unit.
//   addr_lo_i      in  2   byte offset within the word
//   size_i         in  3   funct3 access size/sign
//   ren_i, wen_i   in  1   request direction (both high is illegal)
//   wdata_i        in  32  raw store data
//   rdata_i        in  32  raw bus read word
//   strobe_o       out 4   byte-lane enables
//   wdata_lanes_o  out 32  store data replicated across lanes
//   fault_o        out 2   fault class of the request (lsu_fault_t encoding)
//   rdata_ext_o    out 32  selected and sign/zero-extended load data
// -----------------------------------------------------------------------------
module lsu_align
    import common_types_pkg::*;
(
    input  logic [1:0]  addr_lo_i,
    input  logic [2:0]  size_i,
    input  logic        ren_i,
    input  logic        wen_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rdata_i,
    output logic [3:0]  strobe_o,
    output logic [31:0] wdata_lanes_o,
    output logic [1:0]  fault_o,
    output logic [31:0] rdata_ext_o
);

    word_t       rdata_shifted;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    assign rdata_shifted = rdata_i >> {addr_lo_i, 3'b000};
    assign byte_sel      = rdata_shifted[7:0];
    assign half_sel      = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];

    // size[1:0] alone decides the access width; signedness lives in size[2].
    always_comb begin
        strobe_o      = 4'b1111;
        wdata_lanes_o = wdata_i;
        case (size_i[1:0])
            2'b00: begin
                strobe_o      = 4'b0001 << addr_lo_i;
                wdata_lanes_o = {4{wdata_i[7:0]}};
            end
            2'b01: begin
                strobe_o      = 4'b0011 << addr_lo_i;
                wdata_lanes_o = {2{wdata_i[15:0]}};
            end
            default: begin
                strobe_o      = 4'b1111;
                wdata_lanes_o = wdata_i;
            end
        endcase
    end

    // Illegal checks take priority over alignment checks.
    always_comb begin
        fault_o = FLT_NONE;
        if ((ren_i && wen_i) || (size_i == 3'b011) || (size_i == 3'b110) ||
            (size_i == 3'b111) || (wen_i && size_i[2])) begin
            fault_o = FLT_ILLEGAL;
        end else if (((size_i[1:0] == 2'b01) && addr_lo_i[0]) ||
                     ((size_i[1:0] == 2'b10) && (addr_lo_i != 2'b00))) begin
            fault_o = FLT_MISALIGN;
        end
    end

    always_comb begin
        rdata_ext_o = '0;
        case (size_i)
            LS_B:    rdata_ext_o = {{24{byte_sel[7]}}, byte_sel};
            LS_H:    rdata_ext_o = {{16{half_sel[15]}}, half_sel};
            LS_W:    rdata_ext_o = rdata_i;
            LS_BU:   rdata_ext_o = {24'd0, byte_sel};
            LS_HU:   rdata_ext_o = {16'd0, half_sel};
            default: rdata_ext_o = '0;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// -----------------------------------------------------------------------------
// load_store_unit
// RV32I memory stage: turns an ALU effective address into a word-addressed
// data-memory bus access with byte lanes, extends load data, and reports
// misaligned, illegal and bus-timeout faults. Stalls the pipeline until the
// access completes.
//   CLK, nRST         clock (rising edge), asynchronous active-low reset
//   ls_ren/ls_wen     load/store request, held until ls_done is sampled
//   ls_addr/ls_wdata  effective address, store data
//   ls_size           funct3 size/sign
//   ls_rdata          extended load result, valid while ls_done
//   ls_done           one-cycle completion pulse
//   ls_fault          00 none, 01 misaligned, 10 timeout, 11 illegal
//   ls_busy           stall request to the pipeline
//   dmem_*            registered word-aligned bus request, dmem_rdata/ready in
// -----------------------------------------------------------------------------
module load_store_unit
    import common_types_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        ls_ren,
    input  logic        ls_wen,
    input  logic [31:0] ls_addr,
    input  logic [31:0] ls_wdata,
    input  logic [2:0]  ls_size,
    output logic [31:0] ls_rdata,
    output logic        ls_done,
    output logic [1:0]  ls_fault,
    output logic        ls_busy,
    output logic        dmem_ren,
    output logic        dmem_wen,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_strobe,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ready
);

    lsu_state_t  state_q, state_d;
    logic [1:0]  addr_lo_q, addr_lo_d;
    logic [2:0]  size_q, size_d;
    logic [31:0] cnt_q, cnt_d;

    logic        dmem_ren_q, dmem_ren_d;
    logic        dmem_wen_q, dmem_wen_d;
    word_t       dmem_addr_q, dmem_addr_d;
    word_t       dmem_wdata_q, dmem_wdata_d;
    logic [3:0]  dmem_strobe_q, dmem_strobe_d;

    logic        done_q, done_d;
    logic [1:0]  fault_q, fault_d;
    word_t       rdata_q, rdata_d;

    logic        req;
    logic [1:0]  align_addr_lo;
    logic [2:0]  align_size;
    logic [3:0]  align_strobe;
    word_t       align_wdata;
    logic [1:0]  align_fault;
    word_t       align_rdata;

    assign req = ls_ren | ls_wen;

    // One helper serves both phases: in IDLE it classifies the incoming
    // request, afterwards it extracts load data using the latched offset/size.
    assign align_addr_lo = (state_q == IDLE) ? ls_addr[1:0] : addr_lo_q;
    assign align_size    = (state_q == IDLE) ? ls_size      : size_q;

    lsu_align u_align (
        .addr_lo_i     (align_addr_lo),
        .size_i        (align_size),
        .ren_i         (ls_ren),
        .wen_i         (ls_wen),
        .wdata_i       (ls_wdata),
        .rdata_i       (dmem_rdata),
        .strobe_o      (align_strobe),
        .wdata_lanes_o (align_wdata),
        .fault_o       (align_fault),
        .rdata_ext_o   (align_rdata)
    );

    always_comb begin
        state_d       = state_q;
        addr_lo_d     = addr_lo_q;
        size_d        = size_q;
        cnt_d         = cnt_q;
        dmem_ren_d    = dmem_ren_q;
        dmem_wen_d    = dmem_wen_q;
        dmem_addr_d   = dmem_addr_q;
        dmem_wdata_d  = dmem_wdata_q;
        dmem_strobe_d = dmem_strobe_q;
        done_d        = 1'b0;
        fault_d       = FLT_NONE;
        rdata_d       = '0;

        case (state_q)
            IDLE: begin
                if (req) begin
                    addr_lo_d = ls_addr[1:0];
                    size_d    = ls_size;
                    if (align_fault != FLT_NONE) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                        fault_d = align_fault;
                    end else begin
                        // Bus outputs are loaded here so they are valid on
                        // the first BUS cycle without a combinational path.
                        state_d       = BUS;
                        cnt_d         = '0;
                        dmem_ren_d    = ls_ren;
                        dmem_wen_d    = ls_wen;
                        dmem_addr_d   = {ls_addr[31:2], 2'b00};
                        dmem_wdata_d  = align_wdata;
                        dmem_strobe_d = align_strobe;
                    end
                end
            end
            BUS: begin
                if (dmem_ready || ((TIMEOUT_CYCLES != 0) &&
                                   (cnt_q == TIMEOUT_CYCLES - 32'd1))) begin
                    state_d       = DONE;
                    done_d        = 1'b1;
                    dmem_ren_d    = 1'b0;
                    dmem_wen_d    = 1'b0;
                    dmem_addr_d   = '0;
                    dmem_wdata_d  = '0;
                    dmem_strobe_d = '0;
                    // Ready on the limit cycle still counts as success.
                    if (dmem_ready) begin
                        rdata_d = dmem_ren_q ? align_rdata : '0;
                    end else begin
                        fault_d = FLT_TIMEOUT;
                    end
                end else if (TIMEOUT_CYCLES != 0) begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q       <= IDLE;
            addr_lo_q     <= '0;
            size_q        <= '0;
            cnt_q         <= '0;
            dmem_ren_q    <= 1'b0;
            dmem_wen_q    <= 1'b0;
            dmem_addr_q   <= '0;
            dmem_wdata_q  <= '0;
            dmem_strobe_q <= '0;
            done_q        <= 1'b0;
            fault_q       <= '0;
            rdata_q       <= '0;
        end else begin
            state_q       <= state_d;
            addr_lo_q     <= addr_lo_d;
            size_q        <= size_d;
            cnt_q         <= cnt_d;
            dmem_ren_q    <= dmem_ren_d;
            dmem_wen_q    <= dmem_wen_d;
            dmem_addr_q   <= dmem_addr_d;
            dmem_wdata_q  <= dmem_wdata_d;
            dmem_strobe_q <= dmem_strobe_d;
            done_q        <= done_d;
            fault_q       <= fault_d;
            rdata_q       <= rdata_d;
        end
    end

    // Stall while an access is in flight or being accepted; DONE releases
    // the pipeline so the requester can drop its request on ls_done.
    assign ls_busy     = (state_q == BUS) || ((state_q == IDLE) && req);

    assign ls_done     = done_q;
    assign ls_fault    = fault_q;
    assign ls_rdata    = rdata_q;
    assign dmem_ren    = dmem_ren_q;
    assign dmem_wen    = dmem_wen_q;
    assign dmem_addr   = dmem_addr_q;
    assign dmem_wdata  = dmem_wdata_q;
    assign dmem_strobe = dmem_strobe_q;

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

    logic        CLK;
    logic        nRST;
    logic        ls_ren;
    logic        ls_wen;
    logic [31:0] ls_addr;
    logic [31:0] ls_wdata;
    logic [2:0]  ls_size;
    logic [31:0] ls_rdata;
    logic        ls_done;
    logic [1:0]  ls_fault;
    logic        ls_busy;
    logic        dmem_ren;
    logic        dmem_wen;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_strobe;
    logic [31:0] dmem_rdata;
    logic        dmem_ready;

    int total;
    int passed;

    load_store_unit #(.TIMEOUT_CYCLES(4)) dut (
        .CLK         (CLK),
        .nRST        (nRST),
        .ls_ren      (ls_ren),
        .ls_wen      (ls_wen),
        .ls_addr     (ls_addr),
        .ls_wdata    (ls_wdata),
        .ls_size     (ls_size),
        .ls_rdata    (ls_rdata),
        .ls_done     (ls_done),
        .ls_fault    (ls_fault),
        .ls_busy     (ls_busy),
        .dmem_ren    (dmem_ren),
        .dmem_wen    (dmem_wen),
        .dmem_addr   (dmem_addr),
        .dmem_wdata  (dmem_wdata),
        .dmem_strobe (dmem_strobe),
        .dmem_rdata  (dmem_rdata),
        .dmem_ready  (dmem_ready)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic issue(input logic ren, input logic wen, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [2:0] size);
        ls_ren   = ren;
        ls_wen   = wen;
        ls_addr  = addr;
        ls_wdata = wdata;
        ls_size  = size;
    endtask

    task automatic drop_req();
        ls_ren = 1'b0;
        ls_wen = 1'b0;
    endtask

    task automatic test_reset();
        nRST = 1'b0;
        drop_req();
        ls_addr = '0; ls_wdata = '0; ls_size = '0;
        dmem_rdata = '0; dmem_ready = 1'b0;
        step(); step();
        total++; if (ls_done !== 1'b0) $display("FAIL reset_done got %b exp 0", ls_done); else passed++;
        total++; if (ls_busy !== 1'b0) $display("FAIL reset_busy got %b exp 0", ls_busy); else passed++;
        total++; if ({dmem_ren, dmem_wen} !== 2'b00) $display("FAIL reset_ren_wen got %b exp 00", {dmem_ren, dmem_wen}); else passed++;
        total++; if (dmem_strobe !== 4'b0000) $display("FAIL reset_strobe got %b exp 0000", dmem_strobe); else passed++;
        total++; if (ls_rdata !== 32'd0) $display("FAIL reset_rdata got %h exp 0", ls_rdata); else passed++;
        nRST = 1'b1;
        step();
        $display("reset released at %0t", $time);
    endtask

    task automatic test_store_word();
        dmem_ready = 1'b1;
        issue(1'b0, 1'b1, 32'h0000_0100, 32'hDEAD_BEEF, 3'b010);
        #1;
        total++; if (ls_busy !== 1'b1) $display("FAIL sw_busy0 got %b exp 1", ls_busy); else passed++;
        step();
        total++; if (dmem_wen !== 1'b1) $display("FAIL sw_wen got %b exp 1", dmem_wen); else passed++;
        total++; if (dmem_addr !== 32'h0000_0100) $display("FAIL sw_addr got %h exp 00000100", dmem_addr); else passed++;
        total++; if (dmem_strobe !== 4'b1111) $display("FAIL sw_strobe got %b exp 1111", dmem_strobe); else passed++;
        total++; if (dmem_wdata !== 32'hDEAD_BEEF) $display("FAIL sw_wdata got %h exp deadbeef", dmem_wdata); else passed++;
        total++; if (ls_done !== 1'b0) $display("FAIL sw_done1 got %b exp 0", ls_done); else passed++;
        step();
        total++; if (ls_done !== 1'b1) $display("FAIL sw_done2 got %b exp 1", ls_done); else passed++;
        total++; if (ls_fault !== 2'b00) $display("FAIL sw_fault got %b exp 00", ls_fault); else passed++;
        total++; if (ls_busy !== 1'b0) $display("FAIL sw_busy_done got %b exp 0", ls_busy); else passed++;
        total++; if (dmem_wen !== 1'b0) $display("FAIL sw_wen_drop got %b exp 0", dmem_wen); else passed++;
        drop_req();
        step();
        total++; if (ls_done !== 1'b0) $display("FAIL sw_done_pulse got %b exp 0", ls_done); else passed++;
        $display("SW 0xdeadbeef @0x100 done");
    endtask

    task automatic test_loads();
        logic [2:0]  sizes  [4];
        logic [31:0] addrs  [4];
        logic [3:0]  strbs  [4];
        logic [31:0] expect_data [4];
        sizes[0] = 3'b000; addrs[0] = 32'h103; strbs[0] = 4'b1000; expect_data[0] = 32'hFFFF_FF80;
        sizes[1] = 3'b100; addrs[1] = 32'h103; strbs[1] = 4'b1000; expect_data[1] = 32'h0000_0080;
        sizes[2] = 3'b101; addrs[2] = 32'h102; strbs[2] = 4'b1100; expect_data[2] = 32'h0000_8012;
        sizes[3] = 3'b001; addrs[3] = 32'h100; strbs[3] = 4'b0011; expect_data[3] = 32'h0000_3456;
        dmem_rdata = 32'h8012_3456;
        dmem_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            issue(1'b1, 1'b0, addrs[i], 32'h0, sizes[i]);
            step();
            total++; if (dmem_ren !== 1'b1) $display("FAIL ld%0d_ren got %b exp 1", i, dmem_ren); else passed++;
            total++; if (dmem_addr !== 32'h100) $display("FAIL ld%0d_addr got %h exp 00000100", i, dmem_addr); else passed++;
            total++; if (dmem_strobe !== strbs[i]) $display("FAIL ld%0d_strobe got %b exp %b", i, dmem_strobe, strbs[i]); else passed++;
            step();
            total++; if (ls_done !== 1'b1) $display("FAIL ld%0d_done got %b exp 1", i, ls_done); else passed++;
            total++; if (ls_rdata !== expect_data[i]) $display("FAIL ld%0d_rdata got %h exp %h", i, ls_rdata, expect_data[i]); else passed++;
            total++; if (ls_fault !== 2'b00) $display("FAIL ld%0d_fault got %b exp 00", i, ls_fault); else passed++;
            drop_req();
            step();
            $display("LOAD size=%b @%h -> %h", sizes[i], addrs[i], expect_data[i]);
        end
    endtask

    task automatic test_store_sub_word();
        dmem_ready = 1'b1;
        issue(1'b0, 1'b1, 32'h0000_0202, 32'h1234_ABCD, 3'b001);
        step();
        total++; if (dmem_addr !== 32'h200) $display("FAIL sh_addr got %h exp 00000200", dmem_addr); else passed++;
        total++; if (dmem_strobe !== 4'b1100) $display("FAIL sh_strobe got %b exp 1100", dmem_strobe); else passed++;
        total++; if (dmem_wdata !== 32'hABCD_ABCD) $display("FAIL sh_wdata got %h exp abcdabcd", dmem_wdata); else passed++;
        step();
        total++; if (ls_done !== 1'b1) $display("FAIL sh_done got %b exp 1", ls_done); else passed++;
        total++; if (ls_rdata !== 32'd0) $display("FAIL sh_rdata got %h exp 0", ls_rdata); else passed++;
        drop_req();
        step();
        $display("SH 0x1234abcd @0x202 done");

        issue(1'b0, 1'b1, 32'h0000_0301, 32'h0000_00A5, 3'b000);
        step();
        total++; if (dmem_strobe !== 4'b0010) $display("FAIL sb_strobe got %b exp 0010", dmem_strobe); else passed++;
        total++; if (dmem_wdata !== 32'hA5A5_A5A5) $display("FAIL sb_wdata got %h exp a5a5a5a5", dmem_wdata); else passed++;
        step();
        drop_req();
        step();
        $display("SB 0xa5 @0x301 done");

        issue(1'b0, 1'b1, 32'h0000_0300, 32'h0000_0011, 3'b100);
        step();
        total++; if (dmem_wen !== 1'b0) $display("FAIL sbu_wen got %b exp 0", dmem_wen); else passed++;
        total++; if (ls_done !== 1'b1) $display("FAIL sbu_done got %b exp 1", ls_done); else passed++;
        total++; if (ls_fault !== 2'b11) $display("FAIL sbu_fault got %b exp 11", ls_fault); else passed++;
        drop_req();
        step();
        $display("store size=100 rejected");
    endtask

    task automatic test_faults();
        dmem_ready = 1'b1;
        dmem_rdata = 32'h1111_2222;
        issue(1'b1, 1'b0, 32'h0000_0101, 32'h0, 3'b010);
        step();
        total++; if (ls_done !== 1'b1) $display("FAIL lw_mis_done got %b exp 1", ls_done); else passed++;
        total++; if (ls_fault !== 2'b01) $display("FAIL lw_mis_fault got %b exp 01", ls_fault); else passed++;
        total++; if (ls_rdata !== 32'd0) $display("FAIL lw_mis_rdata got %h exp 0", ls_rdata); else passed++;
        total++; if (dmem_ren !== 1'b0) $display("FAIL lw_mis_ren got %b exp 0", dmem_ren); else passed++;
        drop_req();
        step();
        total++; if (dmem_ren !== 1'b0) $display("FAIL lw_mis_ren_after got %b exp 0", dmem_ren); else passed++;
        $display("LW @0x101 misaligned");

        issue(1'b1, 1'b0, 32'h0000_0101, 32'h0, 3'b001);
        step();
        total++; if (ls_fault !== 2'b01) $display("FAIL lh_mis_fault got %b exp 01", ls_fault); else passed++;
        drop_req();
        step();
        $display("LH @0x101 misaligned");

        issue(1'b1, 1'b1, 32'h0000_0101, 32'h0, 3'b010);
        step();
        total++; if (ls_done !== 1'b1) $display("FAIL rw_done got %b exp 1", ls_done); else passed++;
        total++; if (ls_fault !== 2'b11) $display("FAIL rw_fault got %b exp 11", ls_fault); else passed++;
        drop_req();
        step();
        $display("ren&wen rejected");
    endtask

    task automatic test_timeout();
        int   ren_cycles;
        logic got_done;
        logic [1:0]  flt;
        logic [31:0] rd;
        ren_cycles = 0; got_done = 1'b0; flt = 2'b00; rd = 32'hX;
        dmem_ready = 1'b0;
        dmem_rdata = 32'hCAFE_F00D;
        issue(1'b1, 1'b0, 32'h0000_0040, 32'h0, 3'b010);
        for (int k = 0; k < 12 && !got_done; k++) begin
            step();
            if (dmem_ren) ren_cycles++;
            if (ls_done) begin
                got_done = 1'b1;
                flt = ls_fault;
                rd = ls_rdata;
            end
        end
        total++; if (got_done !== 1'b1) $display("FAIL to_done got %b exp 1", got_done); else passed++;
        total++; if (ren_cycles != 4) $display("FAIL to_ren_cycles got %0d exp 4", ren_cycles); else passed++;
        total++; if (flt !== 2'b10) $display("FAIL to_fault got %b exp 10", flt); else passed++;
        total++; if (rd !== 32'd0) $display("FAIL to_rdata got %h exp 0", rd); else passed++;
        drop_req();
        step();
        $display("LW @0x40 timed out after %0d cycles", ren_cycles);

        issue(1'b1, 1'b0, 32'h0000_0044, 32'h0, 3'b010);
        for (int k = 1; k <= 4; k++) begin
            step();
            if (k == 4) dmem_ready = 1'b1;
        end
        total++; if (dmem_ren !== 1'b1) $display("FAIL to4_ren got %b exp 1", dmem_ren); else passed++;
        step();
        dmem_ready = 1'b0;
        total++; if (ls_done !== 1'b1) $display("FAIL to4_done got %b exp 1", ls_done); else passed++;
        total++; if (ls_fault !== 2'b00) $display("FAIL to4_fault got %b exp 00", ls_fault); else passed++;
        total++; if (ls_rdata !== 32'hCAFE_F00D) $display("FAIL to4_rdata got %h exp cafef00d", ls_rdata); else passed++;
        drop_req();
        step();
        $display("LW @0x44 ready on limit cycle");
    endtask

    task automatic test_reset_mid_access();
        dmem_ready = 1'b0;
        issue(1'b0, 1'b1, 32'h0000_0020, 32'h5555_AAAA, 3'b010);
        step();
        total++; if (dmem_wen !== 1'b1) $display("FAIL rst_mid_wen_before got %b exp 1", dmem_wen); else passed++;
        #2;
        nRST = 1'b0;
        drop_req();
        #1;
        total++; if (dmem_wen !== 1'b0) $display("FAIL rst_mid_wen_async got %b exp 0", dmem_wen); else passed++;
        step();
        total++; if (ls_done !== 1'b0) $display("FAIL rst_mid_done got %b exp 0", ls_done); else passed++;
        nRST = 1'b1;
        dmem_ready = 1'b1;
        step();
        total++; if (ls_done !== 1'b0) $display("FAIL rst_rel_done got %b exp 0", ls_done); else passed++;
        issue(1'b0, 1'b1, 32'h0000_0010, 32'h0BAD_F00D, 3'b010);
        step();
        total++; if (dmem_addr !== 32'h10) $display("FAIL rst_sw_addr got %h exp 00000010", dmem_addr); else passed++;
        step();
        total++; if (ls_done !== 1'b1) $display("FAIL rst_sw_done got %b exp 1", ls_done); else passed++;
        total++; if (ls_fault !== 2'b00) $display("FAIL rst_sw_fault got %b exp 00", ls_fault); else passed++;
        drop_req();
        step();
        $display("reset mid-access then SW @0x10 done");
    endtask

    task automatic test_back_to_back();
        dmem_ready = 1'b1;
        dmem_rdata = 32'h0102_0304;
        issue(1'b1, 1'b0, 32'h0000_0000, 32'h0, 3'b010);
        step();
        step();
        total++; if (ls_rdata !== 32'h0102_0304) $display("FAIL b2b_first_rdata got %h exp 01020304", ls_rdata); else passed++;
        // Request kept high through DONE with a new address: must be ignored there.
        ls_addr = 32'h0000_0008;
        step();
        total++; if (dmem_ren !== 1'b0) $display("FAIL b2b_idle_ren got %b exp 0", dmem_ren); else passed++;
        total++; if (ls_busy !== 1'b1) $display("FAIL b2b_idle_busy got %b exp 1", ls_busy); else passed++;
        step();
        total++; if (dmem_addr !== 32'h8) $display("FAIL b2b_second_addr got %h exp 00000008", dmem_addr); else passed++;
        step();
        total++; if (ls_done !== 1'b1) $display("FAIL b2b_second_done got %b exp 1", ls_done); else passed++;
        drop_req();
        step();
        $display("back-to-back LW @0x0, @0x8 done");
    endtask

    initial begin
        total  = 0;
        passed = 0;
        test_reset();
        test_store_word();
        test_loads();
        test_store_sub_word();
        test_faults();
        test_timeout();
        test_reset_mid_access();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
